data_sram: RTL and testbench

DATA_SRAM -- requirements
Module: data_sram

---
 rtl/data_sram.sv | 222 ++++++++++++++++++++++
 tb/tb_data_sram.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram.sv
// data_sram: byte-addressable, little-endian data memory with a single-request
// valid/ready front end and a registered response.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (accept when both high at an edge)
//   req_we                  1 = store, 0 = load
//   req_size                00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned            loads: 1 = zero-extend, 0 = sign-extend
//   req_addr [ADDR_W]       byte address
//   req_wdata [32]          store data, right-justified
//   rsp_valid               one-cycle pulse per accepted request
//   rsp_rdata [32]          extended load data (0 for stores and errors)
//   rsp_err                 request was rejected
//
// Configuration macro: MISALIGN_SPLIT_EN
//   defined   - accesses crossing a word boundary run as two beats (SPLIT state)
//   undefined - crossing accesses are rejected with rsp_err, latency 1
module data_sram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IW    = ADDR_W - 2;
    localparam int DEPTH = 2 ** IW;

    // Four byte lanes; lane l holds byte address (word*4 + l).
    logic [7:0] mem [4][DEPTH];

    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          accept;
    logic [1:0]    off;
    logic [IW-1:0] idx;
    logic [3:0]    size_mask;
    logic [7:0]    mask_wide;
    logic          crossing;
    logic          reject;
    logic [31:0]   wd_lo;

    logic          wr_en;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;
    logic [IW-1:0] mem_idx;
    logic [31:0]   rd_word;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            2'b00:   return uns ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign accept = req_valid & ready_q;
    assign off    = req_addr[1:0];
    assign idx    = req_addr[ADDR_W-1:2];

    always_comb begin
        case (req_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    end

    // Byte enables over two consecutive words; upper nibble set means the
    // access spills into word idx+1.
    assign mask_wide = {4'b0000, size_mask} << off;
    assign crossing  = |mask_wide[7:4];
    assign wd_lo     = req_wdata << {off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [IW-1:0] idx1_q, idx1_d;
    logic [31:0]   wd_hi_q, wd_hi_d;
    logic [3:0]    mask_hi_q, mask_hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   rd_join;

    assign reject  = (req_size == 2'b11);
    assign mem_idx = (state_q == SPLIT) ? idx1_q : idx;
    // Beat-1 word (saved) and beat-2 word joined, then aligned to byte 0.
    assign rd_join = 32'({rd_word, lo_q} >> {off_q, 3'b000});
`else
    assign reject  = (req_size == 2'b11) | crossing;
    assign mem_idx = idx;
`endif

    assign rd_word = {mem[3][mem_idx], mem[2][mem_idx], mem[1][mem_idx], mem[0][mem_idx]};

    always_comb begin
        wr_en       = 1'b0;
        wr_mask     = 4'b0000;
        wr_data     = wd_lo;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        off_d     = off_q;
        idx1_d    = idx1_q;
        wd_hi_d   = wd_hi_q;
        mask_hi_d = mask_hi_q;
        lo_d      = lo_q;
        if (state_q == SPLIT) begin
            wr_en       = we_q;
            wr_mask     = mask_hi_q;
            wr_data     = wd_hi_q;
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? '0 : extend(rd_join, size_q, uns_q);
        end else
`endif
        if (accept) begin
            if (reject) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
`ifdef MISALIGN_SPLIT_EN
            else if (crossing) begin
                wr_en     = req_we;
                wr_mask   = mask_wide[3:0];
                state_d   = SPLIT;
                ready_d   = 1'b0;
                we_d      = req_we;
                size_d    = req_size;
                uns_d     = req_unsigned;
                off_d     = off;
                idx1_d    = idx + {{(IW-1){1'b0}}, 1'b1};
                wd_hi_d   = req_wdata >> (6'd32 - {1'b0, off, 3'b000});
                mask_hi_d = mask_wide[7:4];
                lo_d      = rd_word;
            end
`endif
            else begin
                wr_en       = req_we;
                wr_mask     = mask_wide[3:0];
                rsp_valid_d = 1'b1;
                rsp_rdata_d = req_we ? '0 : extend(rd_word >> {off, 3'b000}, req_size, req_unsigned);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            off_q     <= '0;
            idx1_q    <= '0;
            wd_hi_q   <= '0;
            mask_hi_q <= '0;
            lo_q      <= '0;
`endif
        end else begin
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef MISALIGN_SPLIT_EN
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            off_q     <= off_d;
            idx1_q    <= idx1_d;
            wd_hi_q   <= wd_hi_d;
            mask_hi_q <= mask_hi_d;
            lo_q      <= lo_d;
`endif
        end
    end

    // Storage is not reset; writes are only possible after an accept, which
    // reset blocks by holding req_ready low.
    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < 4; l++) begin
            if (wr_en && wr_mask[l]) begin
                mem[l][mem_idx] <= wr_data[8*l +: 8];
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_sram.sv
module tb_data_sram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [65536];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    data_sram #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [15:0] a, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eerr, input int elat);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.exp_rd = erd; v.exp_err = eerr; v.exp_lat = elat;
        tbl.push_back(v);
    endfunction

    // Reference: byte-array memory, rules applied byte by byte.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [15:0] a, input logic [31:0] wd,
                         output logic [31:0] erd, output logic eerr, output int elat);
        int n, o;
        logic [31:0] v;
        erd = '0; eerr = 1'b0; elat = 1;
        if (sz == 2'b11) begin eerr = 1'b1; return; end
        n = 1 << sz;
        o = int'(a[1:0]);
        if (o + n > 4) begin
`ifdef MISALIGN_SPLIT_EN
            elat = 2;
`else
            eerr = 1'b1;
            return;
`endif
        end
        if (we) begin
            for (int i = 0; i < n; i++) mdl[16'(int'(a) + i)] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[16'(int'(a) + i)];
            if (!uns) begin
                if (n == 1) v = {{24{v[7]}}, v[7:0]};
                else if (n == 2) v = {{16{v[15]}}, v[15:0]};
            end
            erd = v;
        end
    endtask

    // One request: drive at negedge, wait for accept (bounded), scramble
    // inputs, then wait for the response (bounded) measuring latency.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_after);
        int n;
        logic rdy;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        n = 0;
        do begin
            rdy = req_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 20);
        #1;
        if (!rdy) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1 within 20 cycles");
        end
        rdy_after = req_ready;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = 16'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        er, eerr, ra;
        int          lat, elat;
        logic [15:0] a;
        logic [1:0]  sz;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", {31'b0, req_ready}, 32'd1);

        // Initialise the regions used below so the model knows every byte.
        for (int w = 0; w < 16; w++) begin
            a = 16'(w * 4);
            model(1'b1, 2'b10, 1'b0, a, $urandom, erd, eerr, elat);
        end
        for (int w = 0; w < 16; w++) begin
            a = 16'(w * 4);
            do_req(1'b1, 2'b10, 1'b0, a, {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]}, rd, er, lat, ra);
            a = 16'hFFC0 + 16'(w * 4);
            model(1'b1, 2'b10, 1'b0, a, $urandom, erd, eerr, elat);
            do_req(1'b1, 2'b10, 1'b0, a, {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]}, rd, er, lat, ra);
        end

        // Directed vector table
        add(1, 2'd2, 0, 16'h0010, 32'h8899AABB, 32'h0, 0, 1);
        add(0, 2'd2, 0, 16'h0010, 32'h0, 32'h8899AABB, 0, 1);
        add(0, 2'd0, 0, 16'h0011, 32'h0, 32'hFFFFFFAA, 0, 1);
        add(0, 2'd1, 1, 16'h0012, 32'h0, 32'h00008899, 0, 1);
        add(1, 2'd0, 0, 16'h0013, 32'hFFFFFF11, 32'h0, 0, 1);
        add(0, 2'd2, 0, 16'h0010, 32'h0, 32'h1199AABB, 0, 1);
        add(0, 2'd1, 0, 16'h0012, 32'h0, 32'h00001199, 0, 1);
        add(0, 2'd0, 1, 16'h0010, 32'h0, 32'h000000BB, 0, 1);
        add(0, 2'd0, 0, 16'h0010, 32'h0, 32'hFFFFFFBB, 0, 1);
        add(0, 2'd1, 0, 16'h0011, 32'h0, 32'hFFFF99AA, 0, 1);
        add(0, 2'd1, 1, 16'h0011, 32'h0, 32'h000099AA, 0, 1);
        add(0, 2'd2, 1, 16'h0010, 32'h0, 32'h1199AABB, 0, 1);
        add(1, 2'd2, 0, 16'h0020, 32'h0BADCAFE, 32'h0, 0, 1);
        add(1, 2'd3, 0, 16'h0020, 32'h12345678, 32'h0, 1, 1);
        add(0, 2'd3, 0, 16'h0020, 32'h0, 32'h0, 1, 1);
        add(0, 2'd2, 0, 16'h0020, 32'h0, 32'h0BADCAFE, 0, 1);
        add(1, 2'd2, 0, 16'h0024, 32'h55667788, 32'h0, 0, 1);
        add(0, 2'd1, 0, 16'h0021, 32'h0, 32'hFFFFADCA, 0, 1);
`ifdef MISALIGN_SPLIT_EN
        add(0, 2'd2, 0, 16'h0021, 32'h0, 32'h880BADCA, 0, 2);
        add(0, 2'd1, 0, 16'h0023, 32'h0, 32'hFFFF880B, 0, 2);
`else
        add(0, 2'd2, 0, 16'h0021, 32'h0, 32'h0, 1, 1);
        add(1, 2'd1, 0, 16'h0023, 32'h0000AAAA, 32'h0, 1, 1);
        add(0, 2'd2, 0, 16'h0020, 32'h0, 32'h0BADCAFE, 0, 1);
        add(0, 2'd2, 0, 16'h0024, 32'h0, 32'h55667788, 0, 1);
`endif
        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, ra);
            model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, erd, eerr, elat);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
        end

        // Back-to-back: store then overlapping load on consecutive edges
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 16'h0030; req_wdata = 32'hA5C3_0F96;
        @(posedge clk); #1;
        check("b2b_store_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b_ready", {31'b0, req_ready}, 32'd1);
        req_we = 1'b0; req_size = 2'b01; req_addr = 16'h0031;
        @(posedge clk); #1;
        check("b2b_load_valid", {31'b0, rsp_valid}, 32'd1);
        check("b2b_load_rdata", rsp_rdata, 32'hFFFFC30F);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle_valid", {31'b0, rsp_valid}, 32'd0);
        model(1'b1, 2'b10, 1'b0, 16'h0030, 32'hA5C3_0F96, erd, eerr, elat);

`ifdef MISALIGN_SPLIT_EN
        // Crossing store: ready low for one cycle, latency 2
        do_req(1'b1, 2'b10, 1'b0, 16'h0007, 32'hDEADBEEF, rd, er, lat, ra);
        model(1'b1, 2'b10, 1'b0, 16'h0007, 32'hDEADBEEF, erd, eerr, elat);
        check("split_ready_low", {31'b0, ra}, 32'd0);
        check("split_latency", lat, 32'd2);
        check("split_err", {31'b0, er}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 16'h0004, 32'h0, rd, er, lat, ra);
        check("split_lo_byte3", {24'b0, rd[31:24]}, 32'h000000EF);
        do_req(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, rd, er, lat, ra);
        check("split_hi_bytes", {8'b0, rd[23:0]}, 32'h00DEADBE);

        // Wrap at the top word
        do_req(1'b1, 2'b01, 1'b0, 16'hFFFF, 32'h00001234, rd, er, lat, ra);
        model(1'b1, 2'b01, 1'b0, 16'hFFFF, 32'h00001234, erd, eerr, elat);
        check("wrap_store_latency", lat, 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 16'h0000, 32'h0, rd, er, lat, ra);
        check("wrap_load_byte0", rd, 32'h00000012);
        do_req(1'b0, 2'b00, 1'b1, 16'hFFFF, 32'h0, rd, er, lat, ra);
        check("wrap_load_byteFFFF", rd, 32'h00000034);

        // Reset in the SPLIT cycle of a crossing store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 16'h0035; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rst_split_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_split_valid0", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rst_split_valid1", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_split_ready_release", {31'b0, req_ready}, 32'd1);
        check("rst_split_valid2", {31'b0, rsp_valid}, 32'd0);
        mdl[16'h0035] = 8'h0D; mdl[16'h0036] = 8'hF0; mdl[16'h0037] = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0035 + 16'(i);
            do_req(1'b0, 2'b00, 1'b1, a, 32'h0, rd, er, lat, ra);
            check($sformatf("rst_split_byte%0d", i), rd, {24'b0, mdl[a]});
        end
`endif

        // Randomised traffic against the byte-array model
        for (int k = 0; k < 400; k++) begin
            logic we, uns;
            logic [31:0] wd;
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a   = $urandom_range(0, 1) ? 16'($urandom_range(0, 60)) : 16'hFFC0 + 16'($urandom_range(0, 63));
            wd  = $urandom;
            model(we, sz, uns, a, wd, erd, eerr, elat);
            do_req(we, sz, uns, a, wd, rd, er, lat, ra);
            check($sformatf("rand%0d_rdata", k), rd, erd);
            check($sformatf("rand%0d_err", k), {31'b0, er}, {31'b0, eerr});
            check($sformatf("rand%0d_latency", k), lat, elat);
            check($sformatf("rand%0d_ready_after", k), {31'b0, ra}, (elat == 2) ? 32'd0 : 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
